// File: rtl/float8_accum_pkg.sv
// float8_accum_pkg
// Shared definitions for the Float8 dot-product accumulator:
//   - Float8 field positions ([7] sign, [6:4] exponent, [3:0] mantissa)
//   - exponent bias and the fixed-point fractional width used by the accumulator
//   - saturation magnitude code written on overflow
//   - FSM state encoding for the accumulate / normalise / pack sequence
package float8_accum_pkg;

  localparam int F8_SIGN_BIT = 7;
  localparam int F8_EXP_MSB  = 6;
  localparam int F8_EXP_LSB  = 4;
  localparam int F8_MAN_MSB  = 3;
  localparam int F8_MAN_LSB  = 0;
  localparam int F8_MAN_W    = 4;
  localparam int F8_EXP_BIAS = 3;
  localparam int FRAC_W      = 7;

  localparam logic [6:0] F8_SAT = 7'h7F;

  typedef enum logic [2:0] {
    ACCUM,
    ABS,
    NORM,
    PACK,
    DONE
  } state_t;

endpackage

// File: rtl/float8_accum_f8_to_fixed.sv
// f8_to_fixed
// Combinational conversion of one Float8 term to a two's-complement fixed-point
// value with FRAC_W fractional bits, sized to the accumulator.
// Ports:
//   data : Float8 term
//   ovf  : multiplier overflow flag paired with data; a flagged term converts to 0
//   term : signed fixed-point contribution (ACC_W bits)
module f8_to_fixed
  import float8_accum_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [7:0]       data,
  input  logic             ovf,
  output logic [ACC_W-1:0] term
);

  // 1.M * 2^(E-bias) scaled by 2^FRAC_W is {1,M} shifted by E plus this
  // adjustment; with the current format it works out to zero.
  localparam int SHIFT_ADJ = FRAC_W - F8_MAN_W - F8_EXP_BIAS;

  logic             sign;
  logic [2:0]       expo;
  logic [3:0]       man;
  logic [ACC_W-1:0] mag;

  always_comb begin
    sign = data[F8_SIGN_BIT];
    expo = data[F8_EXP_MSB:F8_EXP_LSB];
    man  = data[F8_MAN_MSB:F8_MAN_LSB];
    mag  = ACC_W'({1'b1, man}) << (int'(expo) + SHIFT_ADJ);
    // Both 0x00 and 0x80 are zero; overflowed products are dropped here and
    // reported through the sticky flag instead.
    if (ovf || (data[F8_EXP_MSB:F8_MAN_LSB] == 7'd0)) begin
      term = '0;
    end else if (sign) begin
      term = -mag;
    end else begin
      term = mag;
    end
  end

endmodule

// File: rtl/float8_accum.sv
// float8_accum
// Accumulates a stream of Float8 products in a fixed-point register, then
// normalises the sum back to Float8 with truncation, underflow flush to zero
// and saturation on overflow.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : term handshake (ready only while accumulating)
//   in_data, in_ovf        : Float8 term and its multiplier overflow flag
//   in_last                : final term of the vector
//   out_valid/out_ready    : result handshake
//   out_data, out_overflow : Float8 result and sticky per-vector overflow
module float8_accum
  import float8_accum_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_ovf,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_overflow
);

  localparam int K_W   = $clog2(ACC_W);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  localparam logic [K_W:0]     P_TOP   = ACC_W - 1;
  localparam logic [K_W:0]     P_LOW   = 4;
  localparam logic [K_W:0]     P_HIGH  = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = MAX_TERMS;

  state_t state, state_next;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] mag;
  logic             sign;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] count;
  logic             ovf_flag;
  logic             cnt_flag;
  logic             accept;

  logic [K_W:0]     p;
  logic [2:0]       e_field;
  logic [3:0]       man_field;
  logic [7:0]       pack_data;
  logic             pack_ovf;

  f8_to_fixed #(.ACC_W(ACC_W)) u_conv (
    .data (in_data),
    .ovf  (in_ovf),
    .term (term)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (accept && in_last) state_next = ABS;
      // acc is zero exactly when |acc| is zero, so no normalisation is needed.
      ABS:   state_next = (acc == '0) ? PACK : NORM;
      NORM:  if (mag[ACC_W-1]) state_next = PACK;
      PACK:  state_next = DONE;
      DONE:  if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // After normalisation the leading one sits at bit ACC_W-1, so its original
  // position is p = ACC_W-1-k and the mantissa is the next four bits down.
  always_comb begin
    p         = P_TOP - {1'b0, k};
    e_field   = 3'(p - P_LOW);
    man_field = mag[ACC_W-2 -: F8_MAN_W];
    pack_data = 8'h00;
    pack_ovf  = 1'b0;
    if (ovf_flag || cnt_flag) begin
      pack_data = {sign, F8_SAT};
      pack_ovf  = 1'b1;
    end else if ((mag == '0) || (p < P_LOW)) begin
      pack_data = 8'h00;
    end else if (p > P_HIGH) begin
      pack_data = {sign, F8_SAT};
      pack_ovf  = 1'b1;
    end else begin
      pack_data = {sign, e_field, man_field};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      mag          <= '0;
      sign         <= 1'b0;
      k            <= '0;
      count        <= '0;
      ovf_flag     <= 1'b0;
      cnt_flag     <= 1'b0;
      out_data     <= 8'h00;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc + term;
            if (in_ovf) ovf_flag <= 1'b1;
            // The count saturates at MAX_TERMS; any term beyond that trips the flag.
            if (count == CNT_MAX) begin
              cnt_flag <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ABS: begin
          sign <= acc[ACC_W-1];
          mag  <= acc[ACC_W-1] ? -acc : acc;
          k    <= '0;
        end
        NORM: begin
          if (!mag[ACC_W-1]) begin
            mag <= mag << 1;
            k   <= k + 1'b1;
          end
        end
        PACK: begin
          out_data     <= pack_data;
          out_overflow <= pack_ovf;
        end
        DONE: begin
          if (out_ready) begin
            acc          <= '0;
            count        <= '0;
            ovf_flag     <= 1'b0;
            cnt_flag     <= 1'b0;
            out_data     <= 8'h00;
            out_overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float8_accum.sv
// tb_float8_accum
// Self-checking bench for float8_accum: expected results are computed from an
// independent integer model when a vector is driven, queued, and compared when
// the DUT presents its result.
module tb_float8_accum;

  localparam int ACC_W     = 24;
  localparam int MAX_TERMS = 256;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_ovf;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_overflow;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
  } result_t;

  result_t    expected_q[$];
  logic [7:0] vd[$];
  logic       vo[$];

  int compared   = 0;
  int mismatched = 0;

  float8_accum #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ovf       (in_ovf),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer sum in units of 2^-7, then Float8 encoding by
  // locating the highest set bit of the magnitude.
  function automatic result_t model_vector();
    result_t r;
    int      sum = 0;
    int      v;
    int      mag;
    int      p = -1;
    bit      flag = 1'b0;
    bit      s;
    for (int i = 0; i < vd.size(); i++) begin
      if (vo[i]) begin
        flag = 1'b1;
      end else if (vd[i][6:0] != 7'd0) begin
        v = (16 + int'(vd[i][3:0])) << vd[i][6:4];
        sum = vd[i][7] ? sum - v : sum + v;
      end
    end
    if (vd.size() > MAX_TERMS) flag = 1'b1;
    s   = (sum < 0);
    mag = s ? -sum : sum;
    for (int b = 0; b < 31; b++) if (mag[b]) p = b;
    r.data = 8'h00;
    r.ovf  = 1'b0;
    if (flag || p > 11) begin
      r.data = {s, 7'h7F};
      r.ovf  = 1'b1;
    end else if (p >= 4) begin
      r.data = {s, 3'(p - 4), 4'(mag >> (p - 4))};
    end
    return r;
  endfunction

  task automatic drive_term(input logic [7:0] d, input logic o, input logic l);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    if (!in_ready) begin
      mismatched++;
      $display("[TB] FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_ovf   = o;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_ovf   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vector();
    expected_q.push_back(model_vector());
    for (int i = 0; i < vd.size(); i++) drive_term(vd[i], vo[i], i == vd.size() - 1);
  endtask

  task automatic wait_output(output logic [7:0] d, output logic o, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    d = out_data;
    o = out_overflow;
  endtask

  task automatic release_output();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic pop_expected(output result_t r);
    if (expected_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: size=%0d required >0", expected_q.size());
      r = '0;
    end else begin
      r = expected_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compared += 3;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    if (out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
    if (out_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_overflow: got %0b want 0", out_overflow); end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  // Runs the vector currently in vd/vo and checks data, flag and (optionally) latency.
  task automatic run_and_check(input string name, input int want_lat);
    result_t    exp;
    logic [7:0] d;
    logic       o;
    int         cyc;
    send_vector();
    wait_output(d, o, cyc);
    pop_expected(exp);
    compared += 2;
    if (d !== exp.data) begin mismatched++; $display("[TB] FAIL %s_data: got %h want %h", name, d, exp.data); end
    if (o !== exp.ovf) begin mismatched++; $display("[TB] FAIL %s_ovf: got %0b want %0b", name, o, exp.ovf); end
    if (want_lat >= 0) begin
      compared++;
      if (cyc != want_lat) begin mismatched++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, cyc, want_lat); end
    end
    release_output();
  endtask

  task automatic test_basic();
    vd = '{8'h38, 8'h38}; vo = '{1'b0, 1'b0};
    run_and_check("sum_3p0", 18);
    vd = '{8'hB8}; vo = '{1'b0};
    run_and_check("single_neg", 19);
  endtask

  task automatic test_cancel();
    vd = '{8'h38, 8'hB8}; vo = '{1'b0, 1'b0};
    run_and_check("cancel_zero", 2);
  endtask

  task automatic test_underflow();
    vd = '{8'h09, 8'h88}; vo = '{1'b0, 1'b0};
    run_and_check("underflow", 26);
  endtask

  task automatic test_saturate();
    vd.delete(); vo.delete();
    for (int i = 0; i < 16; i++) begin vd.push_back(8'h7F); vo.push_back(1'b0); end
    run_and_check("saturate", 11);
    vd = '{8'h38}; vo = '{1'b1};
    run_and_check("term_ovf", -1);
    vd.delete(); vo.delete();
    for (int i = 0; i < MAX_TERMS; i++) begin vd.push_back(8'h00); vo.push_back(1'b0); end
    run_and_check("max_terms_ok", -1);
    vd.push_back(8'h00); vo.push_back(1'b0);
    run_and_check("max_terms_over", -1);
  endtask

  task automatic test_backpressure();
    result_t    exp;
    logic [7:0] d;
    logic       o;
    int         cyc;
    vd = '{8'h38, 8'h38, 8'h38}; vo = '{1'b0, 1'b0, 1'b0};
    send_vector();
    wait_output(d, o, cyc);
    pop_expected(exp);
    compared += 2;
    if (d !== exp.data) begin mismatched++; $display("[TB] FAIL hold_data: got %h want %h", d, exp.data); end
    if (o !== exp.ovf) begin mismatched++; $display("[TB] FAIL hold_ovf: got %0b want %0b", o, exp.ovf); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared += 3;
      if (out_data !== exp.data) begin mismatched++; $display("[TB] FAIL hold_stable: cycle %0d got %h want %h", i, out_data, exp.data); end
      if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_valid: cycle %0d got %0b want 1", i, out_valid); end
      if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_in_ready: cycle %0d got %0b want 0", i, in_ready); end
    end
    release_output();
    vd = '{8'h38}; vo = '{1'b0};
    run_and_check("after_hold", -1);
  endtask

  task automatic test_reset_norm();
    vd = '{8'h38}; vo = '{1'b0};
    send_vector();
    repeat (4) @(posedge clk);
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_norm_busy: in_ready=%0b want 0", in_ready); end
    rst_n = 1'b0;
    #1;
    void'(expected_q.pop_front());
    compared += 3;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL norm_rst_valid: got %0b want 0", out_valid); end
    if (out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL norm_rst_data: got %h want 00", out_data); end
    if (out_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL norm_rst_ovf: got %0b want 0", out_overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL norm_rst_ready: got %0b want 1", in_ready); end
    vd = '{8'h38}; vo = '{1'b0};
    run_and_check("after_reset", -1);
  endtask

  task automatic test_back_to_back();
    int len;
    for (int n = 0; n < 8; n++) begin
      vd.delete(); vo.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        vd.push_back(8'($urandom_range(0, 255)));
        vo.push_back($urandom_range(0, 15) == 0);
      end
      run_and_check("random", -1);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_ovf    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_cancel();
    test_underflow();
    test_saturate();
    test_backpressure();
    test_reset_norm();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/float8_accum.md
FLOAT8_ACCUM -- requirements
Module: float8_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator width in bits (two's complement).
REQ-002 SHALL have parameter MAX_TERMS, default 256, the largest number of terms per vector before overflow is flagged.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports in_valid/in_ready, input/output, 1 each: the term-stream handshake; a term is accepted when both are 1 on a clock edge.
REQ-006 SHALL have port in_data, input, 8: a Float8 product from the multiplier stage.
REQ-007 SHALL have port in_ovf, input, 1: the multiplier overflow flag paired with in_data.
REQ-008 SHALL have port in_last, input, 1: marks the final term of a vector.
REQ-009 SHALL have ports out_valid/out_ready, output/input, 1 each: the result handshake.
REQ-010 SHALL have port out_data, output, 8: the Float8 dot-product result.
REQ-011 SHALL have port out_overflow, output, 1: sticky per-vector overflow, valid while out_valid=1.

Function
REQ-012 SHALL use Float8 format [7] sign, [6:4] exponent E, [3:0] mantissa M, with value (-1)^s * 1.M * 2^(E-3); magnitude [6:0]=0 is zero (0x80 is also zero).
REQ-013 SHALL convert each accepted nonzero term to fixed point with 7 fractional bits: {1,M} << E, sign-applied; zero terms and terms with in_ovf=1 SHALL contribute 0.
REQ-014 SHALL add the converted term into acc on the accepting edge (no extra latency per term).
REQ-015 SHALL implement FSM states ACCUM, ABS, NORM, PACK, DONE; reset state is ACCUM.
REQ-016 SHALL assert in_ready=1 only in ACCUM.
REQ-017 SHALL go ACCUM->ABS on the edge that accepts a term with in_last=1.
REQ-018 ABS (1 cycle) SHALL latch sign=acc[ACC_W-1] and mag=|acc|.
REQ-019 SHALL go ABS->PACK directly when mag=0; otherwise ABS->NORM.
REQ-020 NORM SHALL shift mag left one bit per cycle, counting shifts k, until mag[ACC_W-1]=1, then go to PACK; this takes at most ACC_W-1 cycles.
REQ-021 PACK SHALL compute p=ACC_W-1-k and E'=p-4, then register the result:
- mag=0 or p<4: out_data=0x00 (underflow flushes to zero, no flag).
- p>11: out_data={sign,7'h7F}, out_overflow=1.
- otherwise: out_data={sign,E'[2:0],M'}, where M' is the 4 bits directly below the leading one, truncated (no rounding).
REQ-022 DONE SHALL hold out_valid=1 with out_data/out_overflow stable until out_ready=1; on that edge it SHALL clear acc, the term count and the flags, and return to ACCUM.
REQ-023 out_overflow SHALL also be set if any term of the vector had in_ovf=1, or if more than MAX_TERMS terms were accepted; when set, out_data SHALL be forced to {sign,7'h7F}.
REQ-024 A vector of one term with in_last=1 SHALL be legal.
REQ-025 Latency from the last-term acceptance to out_valid SHALL be 2 cycles (zero result) or k+3 cycles.

Reset
REQ-026 On rst_n=0, at any time including mid-NORM or in DONE, SHALL immediately set state=ACCUM, acc=0, count=0, flags=0, out_valid=0, out_data=0x00, out_overflow=0, and in_ready=1 once released.

Structure
REQ-027 A shared package SHALL hold the Float8 field positions, the exponent bias (3), the fractional width (7), the saturation code 0x7F and the FSM state encoding.
REQ-028 The sub-module f8_to_fixed (combinational term conversion, REQ-013) SHALL be instantiated once.

Verification
REQ-029 Terms 0x38 then 0x38 (last): the bench SHALL see out_data=0x48, out_overflow=0.
REQ-030 Terms 0x38, 0xB8 (last): the bench SHALL see out_data=0x00, with out_valid 2 cycles after acceptance of the last term.
REQ-031 Terms 0x09, 0x88 (last), acc=1: the bench SHALL see out_data=0x00 (underflow), out_overflow=0.
REQ-032 Sixteen 0x7F terms: the bench SHALL see out_data=0x7F, out_overflow=1; separately, one term with in_ovf=1 SHALL also give out_overflow=1.
REQ-033 With out_ready held 0 for 10 cycles in DONE: out_data SHALL stay stable and in_ready SHALL stay 0; the next vector SHALL start from acc=0.
REQ-034 With rst_n pulsed low during NORM: all outputs SHALL be at reset values, and the following vector 0x38 (last) SHALL give 0x38.
